// File: rtl/add32_slice_sequencer.sv
// 32-bit adder that processes one 4-bit carry-lookahead slice per clock and
// accumulates the group generate/propagate across all eight slices.
module add32_slice_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic        cout,
    output logic        g_out,
    output logic        p_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [2:0]  idx_q, idx_d;
    logic        carry_q, carry_d, gacc_q, gacc_d, pacc_q, pacc_d;
    logic        cout_q, cout_d, g_out_q, g_out_d, p_out_q, p_out_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic [3:0]  sa, sb, sg, sp, sc, ss;
    logic        grp_g, grp_p;

    always_comb begin
        sa = a_q[{idx_q, 2'b00} +: 4];
        sb = b_q[{idx_q, 2'b00} +: 4];
        sg = sa & sb;
        sp = sa | sb;
        sc[0] = carry_q;
        sc[1] = sg[0] | (sp[0] & carry_q);
        sc[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & carry_q);
        sc[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
              | (sp[2] & sp[1] & sp[0] & carry_q);
        ss    = sa ^ sb ^ sc;
        grp_g = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
              | (sp[3] & sp[2] & sp[1] & sg[0]);
        grp_p = &sp;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        gacc_d  = gacc_q;
        pacc_d  = pacc_q;
        cout_d  = cout_q;
        g_out_d = g_out_q;
        p_out_d = p_out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = cin;
                    gacc_d  = 1'b0;
                    pacc_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    for (int unsigned i = 0; i < 8; i++) begin
                        if (idx_q == i[2:0]) sum_d[4*i +: 4] = ss;
                    end
                    carry_d = grp_g | (grp_p & carry_q);
                    gacc_d  = grp_g | (grp_p & gacc_q);
                    pacc_d  = grp_p & pacc_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        cout_d  = carry_d;
                        g_out_d = gacc_d;
                        p_out_d = pacc_d;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the next-state decode.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            gacc_q  <= 1'b0;
            pacc_q  <= 1'b0;
            cout_q  <= 1'b0;
            g_out_q <= 1'b0;
            p_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            gacc_q  <= gacc_d;
            pacc_q  <= pacc_d;
            cout_q  <= cout_d;
            g_out_q <= g_out_d;
            p_out_q <= p_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign g_out = g_out_q;
    assign p_out = p_out_q;

endmodule

// File: tb/tb_add32_slice_sequencer.sv
// Self-checking bench for add32_slice_sequencer: vector table, scoreboard
// queue, and directed sequences for start spam, abort and mid-run reset.
module tb_add32_slice_sequencer;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        g;
        logic        p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, g_out, p_out;
    logic [31:0] sum;

    int unsigned tests = 0;
    int unsigned fails = 0;
    vec_t        sb_q[$];
    vec_t        last_exp;
    vec_t        table_v[8];

    add32_slice_sequencer dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .g_out(g_out),
        .p_out(p_out)
    );

    always #5 clk = ~clk;

    // Group generate is the carry out with zero carry-in; group propagate is
    // every bit having a|b set.
    function automatic vec_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mc);
        vec_t        v;
        logic [32:0] full, gen;
        full  = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};
        gen   = {1'b0, ma} + {1'b0, mb};
        v.a   = ma;
        v.b   = mb;
        v.cin = mc;
        v.sum = full[31:0];
        v.cout = full[32];
        v.g   = gen[32];
        v.p   = &(ma | mb);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input bit spam, input bit abort_too);
        int   cyc;
        int   busy_cnt;
        vec_t e;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; start = 1'b1; abort = abort_too;
        sb_q.push_back(v);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        cyc = 0; busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            if (spam) begin
                start = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        if (busy) busy_cnt++;
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_latency", cyc, 32'd8);
        check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sum", sum, e.sum);
            check("cout", {31'd0, cout}, {31'd0, e.cout});
            check("g_out", {31'd0, g_out}, {31'd0, e.g});
            check("p_out", {31'd0, p_out}, {31'd0, e.p});
            last_exp = e;
        end
        @(negedge clk);
        start = 1'b0;
        if (!busy) busy_cnt += 0;
        check("busy_cycles", busy_cnt, 32'd9);
        check("idle_after_done", {30'd0, busy, done}, 32'd0);
        check("result_held", sum, last_exp.sum);
    endtask

    initial begin
        int   cyc;
        int   dones;
        vec_t v;

        table_v[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        table_v[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        table_v[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0};
        table_v[3] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0};
        table_v[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        table_v[5] = model($urandom, $urandom, 1'b0);
        table_v[6] = model($urandom, $urandom, 1'b1);
        table_v[7] = model(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);

        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_flags", {29'd0, cout, g_out, p_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(table_v[i], 1'b0, 1'b0);

        run_op(table_v[1], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) check("spam_extra_done", {31'd0, done}, 32'd0);
        end

        run_op(table_v[7], 1'b0, 1'b1);

        v = model(32'hFFFF0000, 32'h0000FFFF, 1'b1);
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_flags_kept", {29'd0, cout, g_out, p_out},
              {29'd0, last_exp.cout, last_exp.g, last_exp.p});
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 32'd0);
        run_op(model(32'd1, 32'd2, 1'b0), 1'b0, 1'b0);
        check("abort_follow_sum", sum, 32'h00000003);

        @(negedge clk);
        a = 32'h5; b = 32'h6; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", {30'd0, busy, done}, 32'd0);
        check("midrun_rst_sum", sum, 32'd0);
        check("midrun_rst_flags", {29'd0, cout, g_out, p_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        run_op(model(32'h0000000F, 32'h00000001, 1'b0), 1'b0, 1'b0);
        check("post_rst_sum", sum, 32'h00000010);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
